mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 158 +++++++++++++++
 tb/tb_mem_access_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// RV32I load/store access unit: address generation, alignment/funct3 checks,
// lane masking and replication, load extraction and a bounded wait for read data.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_store_data,
  output logic        resp_valid,
  output logic [31:0] resp_load_data,
  output logic [1:0]  resp_err,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_mask,
  output logic        mem_enable,
  output logic        mem_cmd,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_load_data,
  input  logic        mem_valid
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic MEM_CMD_READ  = 1'b0;
  localparam logic MEM_CMD_WRITE = 1'b1;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISALGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        store;
  logic [2:0]  funct3;
  logic [7:0]  count;

  logic [31:0] req_addr;
  logic        illegal_req;
  logic        misaligned_req;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  // Checks are made on the raw request so an error response needs no extra cycle.
  always_comb begin
    req_addr    = req_base + req_offset;
    illegal_req = req_store ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                            : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    misaligned_req = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    lane_mask = 4'b1111;
    lane_data = store_data;
    case (funct3[1:0])
      2'b00: begin
        lane_mask = 4'b0001 << addr[1:0];
        lane_data = {4{store_data[7:0]}};
      end
      2'b01: begin
        lane_mask = 4'b0011 << addr[1:0];
        lane_data = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted  = mem_load_data >> {addr[1:0], 3'b000};
    load_ext = shifted;
    case (funct3)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // The memory bus is only non-zero while an access is in flight.
  always_comb begin
    req_ready      = (state == S_IDLE);
    resp_valid     = (state == S_RESP);
    mem_enable     = (state == S_ACCESS);
    mem_addr       = mem_enable ? addr : 32'd0;
    mem_mask       = mem_enable ? lane_mask : 4'd0;
    mem_cmd        = (mem_enable && store) ? MEM_CMD_WRITE : MEM_CMD_READ;
    mem_write_data = mem_enable ? lane_data : 32'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      addr           <= 32'd0;
      store_data     <= 32'd0;
      store          <= 1'b0;
      funct3         <= 3'd0;
      count          <= 8'd0;
      resp_load_data <= 32'd0;
      resp_err       <= ERR_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr       <= req_addr;
            store      <= req_store;
            funct3     <= req_funct3;
            store_data <= req_store_data;
            count      <= 8'd0;
            if (illegal_req) begin
              state          <= S_RESP;
              resp_err       <= ERR_ILLEGAL;
              resp_load_data <= 32'd0;
            end else if (misaligned_req) begin
              state          <= S_RESP;
              resp_err       <= ERR_MISALGN;
              resp_load_data <= 32'd0;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (store) begin
            state          <= S_RESP;
            resp_err       <= ERR_OK;
            resp_load_data <= 32'd0;
          end else if (mem_valid) begin
            state          <= S_RESP;
            resp_err       <= ERR_OK;
            resp_load_data <= load_ext;
          end else if (count == LAST_WAIT) begin
            state          <= S_RESP;
            resp_err       <= ERR_TIMEOUT;
            resp_load_data <= 32'd0;
          end else begin
            count <= count + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed cases plus randomized loads/stores
// checked against a byte-level reference model.
module tb_mem_access_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_base = 32'd0;
  logic [31:0] req_offset = 32'd0;
  logic [31:0] req_store_data = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_load_data;
  logic [1:0]  resp_err;
  logic [31:0] mem_addr;
  logic [3:0]  mem_mask;
  logic        mem_enable;
  logic        mem_cmd;
  logic [31:0] mem_write_data;
  logic [31:0] mem_load_data = 32'd0;
  logic        mem_valid = 1'b0;

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_store_data(req_store_data),
    .resp_valid(resp_valid), .resp_load_data(resp_load_data), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_mask(mem_mask), .mem_enable(mem_enable),
    .mem_cmd(mem_cmd), .mem_write_data(mem_write_data),
    .mem_load_data(mem_load_data), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  err;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        cmd;
    int          lat;
    int          en;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cycle = 0;
  int   acc_cycle = 0;
  int   en_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, act, expv, cycle);
    end
  endtask

  // Reference: treats the access as a run of bytes in a 4-byte word.
  function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] base,
                                 input logic [31:0] off, input logic [31:0] data,
                                 input logic [31:0] mword, input int delay);
    exp_t e;
    logic [31:0] a;
    logic [63:0] v;
    int size, lane;
    bit illegal, mis;
    a    = base + off;
    lane = int'(a % 4);
    size = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
    illegal = st ? (f3 > 2) : (f3 == 3 || f3 == 6 || f3 == 7);
    mis  = (a % size) != 0;
    e.addr = a;
    e.cmd  = st;
    e.mask = 4'(((1 << size) - 1) << lane);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = data[8*(i % size) +: 8];
    e.data = 32'd0;
    if (illegal || mis) begin
      e.err = illegal ? 2'b10 : 2'b01;
      e.lat = 1;
      e.en  = 0;
    end else if (st) begin
      e.err = 2'b00;
      e.lat = 2;
      e.en  = 1;
    end else if (delay >= T) begin
      e.err = 2'b11;
      e.lat = 1 + T;
      e.en  = T;
    end else begin
      e.err = 2'b00;
      e.lat = 2 + delay;
      e.en  = delay + 1;
      v = (64'(mword) >> (8 * lane)) & ((64'd1 << (8 * size)) - 64'd1);
      if (f3 < 4 && size < 4 && v[8*size-1]) v = v - (64'd1 << (8 * size));
      e.data = v[31:0];
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (reset && req_valid && req_ready) begin
      acc_cycle = cycle;
      en_cnt = 0;
    end
    cycle++;
  end

  // Monitor: bus contents while accessing, zero bus otherwise, and responses.
  always @(negedge clk) begin
    if (mem_enable) begin
      en_cnt++;
      if (exp_q.size() > 0) begin
        checkOutput("mem_addr", mem_addr, exp_q[0].addr);
        checkOutput("mem_mask", 32'(mem_mask), 32'(exp_q[0].mask));
        checkOutput("mem_cmd", 32'(mem_cmd), 32'(exp_q[0].cmd));
        if (exp_q[0].cmd) checkOutput("mem_write_data", mem_write_data, exp_q[0].wdata);
      end
    end else begin
      checkOutput("mem_idle_zero",
                  32'(mem_addr == 0 && mem_mask == 0 && !mem_cmd && mem_write_data == 0), 32'd1);
    end
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("resp_err", 32'(resp_err), 32'(e.err));
        checkOutput("resp_load_data", resp_load_data, e.data);
        checkOutput("resp_latency", 32'(cycle - acc_cycle), 32'(e.lat));
        checkOutput("enable_cycles", 32'(en_cnt), 32'(e.en));
      end
    end
  end

  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] base,
                               input logic [31:0] off, input logic [31:0] data,
                               input logic [31:0] mword, input int delay);
    int guard;
    int i;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("ready_timeout", 32'd0, 32'd1);
    req_valid      = 1'b1;
    req_store      = st;
    req_funct3     = f3;
    req_base       = base;
    req_offset     = off;
    req_store_data = data;
    exp_q.push_back(model(st, f3, base, off, data, mword, delay));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (i = 0; i < 300; i++) begin
      if (!mem_enable) break;
      mem_valid     = st ? 1'($urandom_range(0, 1)) : (i == delay);
      mem_load_data = mword;
      @(posedge clk);
      #1;
    end
    if (i >= 300) checkOutput("access_stuck", 32'd0, 32'd1);
    mem_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_mem_enable", 32'(mem_enable), 32'd0);
    checkOutput("reset_resp_err", 32'(resp_err), 32'd0);
    checkOutput("reset_resp_data", resp_load_data, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    applyStimulus(1'b1, 3'b000, 32'h100, 32'd3, 32'h12345678, 32'd0, 0);
    applyStimulus(1'b0, 3'b000, 32'h200, 32'd2, 32'd0, 32'h00F10000, 0);
    applyStimulus(1'b0, 3'b100, 32'h200, 32'd2, 32'd0, 32'h00F10000, 0);
    applyStimulus(1'b0, 3'b001, 32'h300, 32'd1, 32'd0, 32'hAAAA5555, 0);
    applyStimulus(1'b0, 3'b010, 32'h400, 32'd0, 32'd0, 32'h11223344, 99);
    applyStimulus(1'b1, 3'b011, 32'h500, 32'd0, 32'hDEADBEEF, 32'd0, 0);
    applyStimulus(1'b1, 3'b001, 32'h10, 32'hFFFFFFFE, 32'hCAFEBABE, 32'd0, 0);
    applyStimulus(1'b0, 3'b001, 32'h600, 32'd2, 32'd0, 32'h8001FFFF, 2);
    applyStimulus(1'b0, 3'b010, 32'h700, 32'd4, 32'd0, 32'h89ABCDEF, T - 1);

    // Abandon a load mid-access with reset; no response may appear.
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'b010;
    req_base   = 32'h800;
    req_offset = 32'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pre_reset_enable", 32'(mem_enable), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("async_reset_enable", 32'(mem_enable), 32'd0);
    checkOutput("async_reset_resp", 32'(resp_valid), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("post_reset_ready", 32'(req_ready), 32'd1);
    checkOutput("post_reset_resp", 32'(resp_valid), 32'd0);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] off;
      off = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, off,
                    $urandom, $urandom, $urandom_range(0, T + 1));
    end

    for (int w = 0; w < 50 && exp_q.size() > 0; w++) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
